uart_param: RTL
===============

# uart_param

Parametrised UART core: the next-generation replacement for the fixed 8N1 UART top. It integrates the baud generator, a transmitter and a 16x-oversampling receiver. Clock rate, baud rate, data width, parity mode and stop-bit count are all parameters. The receiver adds parity-error, framing-error and overrun reporting. The block sits between the board-level serial pins and the on-chip byte-stream logic, and keeps the existing `rdy`/`rdy_clr` and `wr_en`/`tx_busy` handshake semantics.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency in Hz.
- `BAUD`, 115200, line rate in bits/s. Oversample divider `DIV = CLK_HZ / (BAUD*16)`, floor. `DIV >= 1` is required; an elaboration check fails otherwise.
- `DATA_BITS`, 8, data bits per frame. Legal values 5..8. Data is sent LSB first.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits per frame. Legal values 1 or 2.

Ports:
- `clk_50m`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  DATA_BITS  transmit data.
- `wr_en`  in  1  transmit request.
- `tx`  out  1  serial output. Idles high.
- `tx_busy`  out  1  transmitter occupied.
- `rx`  in  1  asynchronous serial input.
- `dout`  out  DATA_BITS  last received data.
- `rdy`  out  1  received data valid.
- `rdy_clr`  in  1  clears `rdy` and the error flags.
- `par_err`  out  1  parity mismatch on the frame held in `dout`.
- `frm_err`  out  1  first stop bit was sampled low.
- `ovr_err`  out  1  a frame completed while `rdy` was already 1. Sticky.

## Operation
- Reset values:
  - `tx`=1, `tx_busy`=0.
  - `dout`=0, `rdy`=0, `par_err`=0, `frm_err`=0, `ovr_err`=0.
  - Both `rx` synchroniser flops=1. All counters 0, both FSMs in IDLE.
- Reset taken mid-frame aborts the frame immediately. No partial byte is delivered.
- Baud generator:
  - A counter 0..DIV-1 pulses `os_tick` for one cycle on wrap.
  - A 4-bit counter on `os_tick` pulses `tx_tick` once every 16 `os_tick`s.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - In IDLE, `wr_en`=1 latches `din` into the shift register and sets `tx_busy`.
  - `wr_en` while `tx_busy`=1 is ignored. `din` is don't-care after acceptance.
  - At the first `tx_tick` after acceptance, the FSM enters START and drives `tx`=0.
  - Each subsequent `tx_tick` advances one bit: DATA_BITS data bits, then the parity bit if PARITY≠0, then STOP_BITS stop bits (`tx`=1).
  - Parity bit = XOR of the data bits, inverted for odd mode.
  - After the last stop period completes (the next `tx_tick`), the FSM returns to IDLE and `tx_busy`=0.
- RX input passes through a 2-flop synchroniser before any use.
- RX FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit sample counter runs on `os_tick`.
  - IDLE to START on the synchronised input low at an `os_tick`.
  - In START, after 8 further `os_tick`s (mid start bit): input still low goes to DATA; input high goes back to IDLE (glitch reject).
  - Each later bit is sampled 16 `os_tick`s after the previous sample.
  - Data bits are shifted in LSB first, then the parity bit if enabled, then stop bits.
  - Only the first stop bit is checked. With STOP_BITS=2 the receiver returns to IDLE after the first stop sample, so back-to-back frames are accepted.
- On the first-stop-bit sample, in a single cycle:
  - `dout` is loaded.
  - `rdy` is set to 1.
  - `par_err` and `frm_err` are loaded for this frame.
  - `ovr_err` is set if `rdy` was already 1.
- The frame is always delivered, including on error; the flags qualify it.
- `rdy_clr`=1 clears `rdy`, `par_err`, `frm_err` and `ovr_err` on the next edge.
- If `rdy_clr` and frame completion coincide, completion wins: `rdy`=1 and the new flags load. `ovr_err` is not set in this case.

## Timing
- `tx_busy` rises on the edge that samples `wr_en`=1.
- The start-bit edge follows 1..16·DIV cycles later, aligned to `tx_tick`.
- Each TX bit lasts exactly 16·DIV cycles.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)·16·DIV cycles.
- `tx_busy` falls at the end of the final stop bit. A new `wr_en` is accepted on that same cycle.
- RX latency from the start-bit falling edge at the pin to `rdy`=1: 2 (synchroniser) + up to DIV (tick phase) + (8 + 16·(DATA_BITS + (PARITY≠0) + 1))·DIV cycles.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Bench parameters: CLK_HZ=1_600_000, BAUD=100_000 (DIV=1, one bit = 16 cycles). Loopback `tx`→`rx`.
- 8N1 round trip: `wr_en` with `din`=0xA5.
  - Frame on `tx`: 0, then 1,0,1,0,0,1,0,1, then 1.
  - `rdy`=1 with `dout`=0xA5 and all error flags 0.
  - `tx_busy` high for exactly 160 cycles after the tick-aligned start.
- PARITY=2, DATA_BITS=7: send 0x41.
  - Parity bit on the wire = 0.
  - Received `dout`=0x41, `par_err`=0.
  - Bench then flips the parity bit on `rx` → `par_err`=1, `dout`=0x41.
- Framing error: drive a frame 0x3C with the stop bit held low → `rdy`=1, `dout`=0x3C, `frm_err`=1.
- Overrun and collision:
  - Two frames 0x11 then 0x22 without `rdy_clr` → `dout`=0x22, `ovr_err`=1.
  - `rdy_clr` asserted on the exact completion cycle of a third frame → `rdy` stays 1 and `ovr_err`=0.
- Glitch and reset:
  - 4-cycle low pulse on `rx` → no `rdy`.
  - Assert `rst` mid-transmission of 0xFF → `tx`=1 and `tx_busy`=0 the next cycle, and no `rdy` follows.
- `wr_en` while `tx_busy`=1 with `din`=0x00 → ignored; the frame in progress finishes unchanged.

Source files
------------

// File: rtl/uart_param.sv
// uart_param: parametrised UART core with a shared baud generator, a transmitter
// and a 16x-oversampling receiver that reports parity, framing and overrun errors.
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line high; when busy, a byte is latched and waits for tx_tick
//   TX_START  | driving the start bit (low)
//   TX_DATA   | driving data bits, LSB first
//   TX_PARITY | driving the parity bit
//   TX_STOP   | driving stop bit(s) (high)
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for a low level on the synchronised input
//   RX_START  | counting to mid start bit, then confirm or reject as a glitch
//   RX_DATA   | sampling data bits every 16 oversample ticks
//   RX_PARITY | sampling the parity bit
//   RX_STOP   | sampling the first stop bit, then delivering the frame
module uart_param #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rdy,
    input  logic                 rdy_clr,
    output logic                 par_err,
    output logic                 frm_err,
    output logic                 ovr_err
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);
    localparam logic          HAS_PAR   = (PARITY != 0);

    if (DIV < 1) begin : g_bad_div
        $error("uart_param: CLK_HZ / (BAUD*16) must be at least 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
        $error("uart_param: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    logic [CW-1:0]        os_cnt;
    logic [3:0]           tick16;
    logic                 os_tick;
    logic                 tx_tick;

    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;
    logic [2:0]           tx_bit;
    logic                 tx_stop;

    logic [1:0]           rx_sync;
    logic                 rx_s;
    rx_state_t            rx_state;
    logic [3:0]           rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_par;
    logic                 rx_done;

    assign os_tick = (os_cnt == DIV_LAST);
    assign tx_tick = os_tick && (tick16 == 4'hF);
    assign rx_s    = rx_sync[1];
    assign rx_done = (rx_state == RX_STOP) && os_tick && (rx_cnt == 4'd0);

    // Oversample divider: one os_tick every DIV clocks, tx_tick every 16 os_ticks.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            os_cnt <= '0;
            tick16 <= 4'd0;
        end else begin
            if (os_tick) begin
                os_cnt <= '0;
                tick16 <= tick16 + 4'd1;
            end else begin
                os_cnt <= os_cnt + 1'b1;
            end
        end
    end

    // Transmitter: accept a byte in IDLE, then emit one bit per tx_tick.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_bit   <= 3'd0;
            tx_stop  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!tx_busy) begin
                        if (wr_en) begin
                            tx_sh   <= din;
                            tx_par  <= (^din) ^ ODD;
                            tx_busy <= 1'b1;
                        end
                    end else if (tx_tick) begin
                        tx_state <= TX_START;
                        tx       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_state <= TX_DATA;
                        tx       <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                        tx_bit   <= 3'd0;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit == LAST_BIT) begin
                            if (HAS_PAR) begin
                                tx_state <= TX_PARITY;
                                tx       <= tx_par;
                            end else begin
                                tx_state <= TX_STOP;
                                tx       <= 1'b1;
                                tx_stop  <= 1'b0;
                            end
                        end else begin
                            tx     <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                            tx_bit <= tx_bit + 3'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_tick) begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                        tx_stop  <= 1'b0;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        if (tx_stop == STOP_LAST) begin
                            tx_state <= TX_IDLE;
                            tx_busy  <= 1'b0;
                        end else begin
                            tx_stop <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchroniser on the asynchronous serial input.
    always_ff @(posedge clk_50m) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], rx};
    end

    // Receiver: rx_cnt is a down-counter to the next mid-bit sample point.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 4'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= '0;
            rx_par   <= 1'b0;
        end else if (os_tick) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= 4'd7;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 4'd0) begin
                        if (!rx_s) begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= 4'd15;
                            rx_bit   <= 3'd0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 4'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 4'd0) begin
                        rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
                        rx_cnt <= 4'd15;
                        if (rx_bit == LAST_BIT) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                        else                    rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 4'd1;
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt == 4'd0) begin
                        rx_par   <= rx_s;
                        rx_cnt   <= 4'd15;
                        rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 4'd1;
                    end
                end
                RX_STOP: begin
                    // Only the first stop bit is checked; a second one is just idle line.
                    if (rx_cnt == 4'd0) rx_state <= RX_IDLE;
                    else                rx_cnt   <= rx_cnt - 4'd1;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame delivery and status flags; a completing frame beats rdy_clr.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            dout    <= '0;
            rdy     <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else if (rx_done) begin
            dout    <= rx_sh;
            rdy     <= 1'b1;
            par_err <= HAS_PAR && (((^rx_sh) ^ ODD) != rx_par);
            frm_err <= !rx_s;
            ovr_err <= rdy_clr ? 1'b0 : (ovr_err | rdy);
        end else if (rdy_clr) begin
            rdy     <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end
    end

endmodule
